// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared display constants for the 640x480 pong video path.
//   X_POS_W / Y_POS_W          : coordinate widths. Y is 10 bits so the
//                                vertical-blank lines (>= 480) stay representable.
//   SCREEN_H_RES / SCREEN_V_RES: active area size.
//   PADDLE_X_L                 : distance of each paddle from its screen edge.
//   obj_e / NUM_OBJ            : index of each hit-tested object.
//   rgb_t, COLOR_*             : 4-bit-per-channel palette, scaled to the
//                                renderer's RGB_W at its outputs.
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int X_POS_W      = 10;
  localparam int Y_POS_W      = 10;
  localparam int SCREEN_H_RES = 640;
  localparam int SCREEN_V_RES = 480;
  localparam int PADDLE_X_L   = 16;

  localparam int NUM_OBJ = 3;
  typedef enum int {
    OBJ_PADDLE_L = 0,
    OBJ_PADDLE_R = 1,
    OBJ_BALL     = 2
  } obj_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COLOR_BG     = '{r: 4'h1, g: 4'h1, b: 4'h3};
  localparam rgb_t COLOR_BALL   = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t COLOR_PADDLE = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb_t COLOR_NET    = '{r: 4'h8, g: 4'h8, b: 4'h8};

endpackage

// File: rtl/pong_renderer_if.sv
// -----------------------------------------------------------------------------
// pong_renderer_if
// Video bundle between the timing generator / game logic and the renderer.
//   *_i signals : timing (syncs, pixel coordinate, visible flag) and object
//                 positions, driven by the master.
//   *_o signals : delayed syncs, RGB and frame_tick, driven by the renderer.
// modport master : timing/game side.  modport slave : pong_renderer.
// -----------------------------------------------------------------------------
interface pong_renderer_if #(
  parameter int RGB_W = 4
);
  import display_pkg::*;

  logic               hsync_i;
  logic               vsync_i;
  logic [X_POS_W-1:0] pixel_x_i;
  logic [Y_POS_W-1:0] pixel_y_i;
  logic               visible_range_i;
  logic [Y_POS_W-1:0] paddle_l_y_i;
  logic [Y_POS_W-1:0] paddle_r_y_i;
  logic [Y_POS_W-1:0] ball_y_i;
  logic [X_POS_W-1:0] ball_x_i;

  logic               hsync_o;
  logic               vsync_o;
  logic [RGB_W-1:0]   red_o;
  logic [RGB_W-1:0]   green_o;
  logic [RGB_W-1:0]   blue_o;
  logic               frame_tick_o;

  modport master (
    output hsync_i, vsync_i, pixel_x_i, pixel_y_i, visible_range_i,
           paddle_l_y_i, paddle_r_y_i, ball_y_i, ball_x_i,
    input  hsync_o, vsync_o, red_o, green_o, blue_o, frame_tick_o
  );

  modport slave (
    input  hsync_i, vsync_i, pixel_x_i, pixel_y_i, visible_range_i,
           paddle_l_y_i, paddle_r_y_i, ball_y_i, ball_x_i,
    output hsync_o, vsync_o, red_o, green_o, blue_o, frame_tick_o
  );

endinterface

// File: rtl/pong_renderer_rect_hit.sv
// -----------------------------------------------------------------------------
// rect_hit
// Registered point-in-rectangle test: hit_o is high one cycle after
// (px_i, py_i) lies in [rx_i, rx_i+W) x [ry_i, ry_i+H).
//   clk_i, rst_i : clock, synchronous active-high reset (clears hit_o)
//   px_i, py_i   : pixel coordinate
//   rx_i, ry_i   : rectangle top-left corner
//   hit_o        : registered hit flag
// -----------------------------------------------------------------------------
module rect_hit #(
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int W   = 8,
  parameter int H   = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [X_W-1:0] px_i,
  input  logic [Y_W-1:0] py_i,
  input  logic [X_W-1:0] rx_i,
  input  logic [Y_W-1:0] ry_i,
  output logic           hit_o
);

  // Upper bounds carry one extra bit so a rectangle hanging over the far
  // screen edge is clipped rather than wrapping back to row/column 0.
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;
  logic         hit_next;
  logic         hit_reg;

  assign x_end = {1'b0, rx_i} + (X_W+1)'(W);
  assign y_end = {1'b0, ry_i} + (Y_W+1)'(H);

  assign hit_next = (px_i >= rx_i) && ({1'b0, px_i} < x_end) &&
                    (py_i >= ry_i) && ({1'b0, py_i} < y_end);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_reg <= 1'b0;
    end else begin
      hit_reg <= hit_next;
    end
  end

  assign hit_o = hit_reg;

endmodule

// File: rtl/pong_renderer.sv
// -----------------------------------------------------------------------------
// pong_renderer
// Two-stage pong pixel renderer.
//   Stage 1: rect_hit tests for both paddles and the ball (plus the optional
//            centre net), syncs and visible flag registered once.
//   Stage 2: colour selection (ball > paddles > net > background) registered,
//            syncs registered again so everything leaves aligned.
// Object positions are sampled into shadow registers at the start of vertical
// blank (the cycle frame_tick_o goes high) so a frame never tears.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   vid          : pong_renderer_if.slave (timing + positions in, RGB/syncs/
//                  frame_tick out)
// Build option: define PONG_CENTER_NET_EN to draw the dashed centre net.
// -----------------------------------------------------------------------------
module pong_renderer
  import display_pkg::*;
#(
  parameter int PADDLE_W = 8,
  parameter int PADDLE_H = 64,
  parameter int BALL_SZ  = 8,
  parameter int RGB_W    = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pong_renderer_if.slave vid
);

  localparam logic [Y_POS_W-1:0] V_RES        = Y_POS_W'(SCREEN_V_RES);
  localparam logic [X_POS_W-1:0] PADDLE_X_LFT = X_POS_W'(PADDLE_X_L);
  localparam logic [X_POS_W-1:0] PADDLE_X_RGT = X_POS_W'(SCREEN_H_RES - PADDLE_X_L - PADDLE_W);
  localparam logic [Y_POS_W-1:0] PADDLE_Y_RST = Y_POS_W'((SCREEN_V_RES - PADDLE_H) / 2);
  localparam logic [X_POS_W-1:0] BALL_X_RST   = X_POS_W'((SCREEN_H_RES - BALL_SZ) / 2);
  localparam logic [Y_POS_W-1:0] BALL_Y_RST   = Y_POS_W'((SCREEN_V_RES - BALL_SZ) / 2);

  // Palette is 4 bits per channel; take its top RGB_W bits, zero-extending
  // on the right when the output is wider.
  function automatic logic [RGB_W-1:0] scale_ch(input logic [3:0] c);
    return RGB_W'({c, {RGB_W{1'b0}}} >> 4);
  endfunction

  // ---------------- frame tick and position shadows ----------------
  logic               in_vblank;
  logic               in_vblank_q;
  logic               frame_start;
  logic               frame_tick_reg;
  logic [Y_POS_W-1:0] paddle_l_y_reg;
  logic [Y_POS_W-1:0] paddle_r_y_reg;
  logic [Y_POS_W-1:0] ball_y_reg;
  logic [X_POS_W-1:0] ball_x_reg;

  assign in_vblank   = (vid.pixel_y_i >= V_RES);
  // Pixel inputs may hold for several clocks; only the first vblank cycle counts.
  assign frame_start = in_vblank && !in_vblank_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_vblank_q    <= 1'b0;
      frame_tick_reg <= 1'b0;
      paddle_l_y_reg <= PADDLE_Y_RST;
      paddle_r_y_reg <= PADDLE_Y_RST;
      ball_y_reg     <= BALL_Y_RST;
      ball_x_reg     <= BALL_X_RST;
    end else begin
      in_vblank_q    <= in_vblank;
      frame_tick_reg <= frame_start;
      if (frame_start) begin
        paddle_l_y_reg <= vid.paddle_l_y_i;
        paddle_r_y_reg <= vid.paddle_r_y_i;
        ball_y_reg     <= vid.ball_y_i;
        ball_x_reg     <= vid.ball_x_i;
      end
    end
  end

  // ---------------- stage 1: hit tests ----------------
  logic [X_POS_W-1:0] obj_x [NUM_OBJ];
  logic [Y_POS_W-1:0] obj_y [NUM_OBJ];
  logic [NUM_OBJ-1:0] hit_q1;

  assign obj_x[OBJ_PADDLE_L] = PADDLE_X_LFT;
  assign obj_y[OBJ_PADDLE_L] = paddle_l_y_reg;
  assign obj_x[OBJ_PADDLE_R] = PADDLE_X_RGT;
  assign obj_y[OBJ_PADDLE_R] = paddle_r_y_reg;
  assign obj_x[OBJ_BALL]     = ball_x_reg;
  assign obj_y[OBJ_BALL]     = ball_y_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
      localparam int OBJ_W = (gi == OBJ_BALL) ? BALL_SZ : PADDLE_W;
      localparam int OBJ_H = (gi == OBJ_BALL) ? BALL_SZ : PADDLE_H;
      rect_hit #(
        .X_W (X_POS_W),
        .Y_W (Y_POS_W),
        .W   (OBJ_W),
        .H   (OBJ_H)
      ) u_hit (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .px_i  (vid.pixel_x_i),
        .py_i  (vid.pixel_y_i),
        .rx_i  (obj_x[gi]),
        .ry_i  (obj_y[gi]),
        .hit_o (hit_q1[gi])
      );
    end
  endgenerate

  logic net_q1;
`ifdef PONG_CENTER_NET_EN
  localparam logic [X_POS_W-1:0] NET_X0 = X_POS_W'(SCREEN_H_RES / 2 - 1);
  localparam logic [X_POS_W-1:0] NET_X1 = X_POS_W'(SCREEN_H_RES / 2 + 1);

  // Two pixels wide, dashed by pixel_y bit 3 (8 rows on, 8 rows off).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      net_q1 <= 1'b0;
    end else begin
      net_q1 <= (vid.pixel_x_i >= NET_X0) && (vid.pixel_x_i < NET_X1) &&
                !vid.pixel_y_i[3];
    end
  end
`else
  assign net_q1 = 1'b0;
`endif

  logic hsync_q1;
  logic vsync_q1;
  logic vis_q1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_q1 <= 1'b0;
      vsync_q1 <= 1'b0;
      vis_q1   <= 1'b0;
    end else begin
      hsync_q1 <= vid.hsync_i;
      vsync_q1 <= vid.vsync_i;
      vis_q1   <= vid.visible_range_i;
    end
  end

  // ---------------- stage 2: colour select ----------------
  rgb_t rgb_next;
  rgb_t rgb_reg;
  logic hsync_reg;
  logic vsync_reg;

  always_comb begin
    rgb_next = COLOR_BG;
    if (!vis_q1) begin
      rgb_next = '0;
    end else if (hit_q1[OBJ_BALL]) begin
      rgb_next = COLOR_BALL;
    end else if (hit_q1[OBJ_PADDLE_L] || hit_q1[OBJ_PADDLE_R]) begin
      rgb_next = COLOR_PADDLE;
    end else if (net_q1) begin
      rgb_next = COLOR_NET;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_reg   <= '0;
      hsync_reg <= 1'b0;
      vsync_reg <= 1'b0;
    end else begin
      rgb_reg   <= rgb_next;
      hsync_reg <= hsync_q1;
      vsync_reg <= vsync_q1;
    end
  end

  assign vid.red_o        = scale_ch(rgb_reg.r);
  assign vid.green_o      = scale_ch(rgb_reg.g);
  assign vid.blue_o       = scale_ch(rgb_reg.b);
  assign vid.hsync_o      = hsync_reg;
  assign vid.vsync_o      = vsync_reg;
  assign vid.frame_tick_o = frame_tick_reg;

endmodule

// File: tb/tb_pong_renderer.sv
// -----------------------------------------------------------------------------
// tb_pong_renderer
// Self-checking bench for pong_renderer (640x480 package values, RGB_W = 4).
// Every driven pixel pushes its expected colour/syncs onto a scoreboard queue
// tagged with the cycle it must appear (2 clocks later); the queue is popped
// and compared on the falling edge. A table covers the static scene, hand
// sequences cover frame boundaries, shadow latching, syncs and reset.
// Honors PONG_CENTER_NET_EN for the expected net colour.
// -----------------------------------------------------------------------------
module tb_pong_renderer;
  import display_pkg::*;

  localparam logic [11:0] C_BG   = 12'h113;
  localparam logic [11:0] C_BALL = 12'hFFF;
  localparam logic [11:0] C_PAD  = 12'h0F0;
`ifdef PONG_CENTER_NET_EN
  localparam logic [11:0] C_NETX = 12'h888;
`else
  localparam logic [11:0] C_NETX = 12'h113;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pong_renderer_if #(.RGB_W(4)) vid ();

  pong_renderer #(
    .PADDLE_W (8),
    .PADDLE_H (64),
    .BALL_SZ  (8),
    .RGB_W    (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .vid   (vid)
  );

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    bit          chk_rgb;
    string       name;
  } exp_t;

  typedef struct {
    int          px;
    int          py;
    bit          vis;
    logic [11:0] rgb;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Advance one clock and retire every scoreboard entry due now.
  task automatic advance();
    exp_t e;
    logic [11:0] got;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      got = {vid.red_o, vid.green_o, vid.blue_o};
      if (e.chk_rgb) chk({e.name, "_rgb"}, 32'(got), 32'(e.rgb));
      chk({e.name, "_sync"}, 32'({vid.hsync_o, vid.vsync_o}), 32'({e.hs, e.vs}));
      $display("txn %-18s rgb=%h hs=%b vs=%b", e.name, got, vid.hsync_o, vid.vsync_o);
    end
  endtask

  task automatic drive(input int px, input int py, input bit vis, input bit hs,
                       input bit vs, input logic [11:0] rgb, input string name);
    exp_t e;
    vid.pixel_x_i       = X_POS_W'(px);
    vid.pixel_y_i       = Y_POS_W'(py);
    vid.visible_range_i = vis;
    vid.hsync_i         = hs;
    vid.vsync_i         = vs;
    e.due     = cyc + 2;
    e.rgb     = rgb;
    e.hs      = hs;
    e.vs      = vs;
    e.chk_rgb = 1'b1;
    e.name    = name;
    sb.push_back(e);
    advance();
  endtask

  task automatic pix(input int px, input int py, input logic [11:0] rgb, input string name);
    drive(px, py, 1'b1, 1'b1, 1'b1, rgb, name);
  endtask

  task automatic set_pos(input int pl, input int pr, input int bx, input int by);
    vid.paddle_l_y_i = Y_POS_W'(pl);
    vid.paddle_r_y_i = Y_POS_W'(pr);
    vid.ball_x_i     = X_POS_W'(bx);
    vid.ball_y_i     = Y_POS_W'(by);
  endtask

  // Four held vblank cycles then two active-area cycles: exactly one tick,
  // visible on the first vblank cycle.
  task automatic frame_boundary();
    int ticks = 0;
    int first = -1;
    for (int i = 0; i < 6; i++) begin
      drive(0, (i < 4) ? 480 : 0, 1'b0, 1'b1, 1'b1, 12'h000, "vblank");
      if (vid.frame_tick_o === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    chk("frame_tick_count", 32'(ticks), 32'd1);
    chk("frame_tick_first", 32'(first), 32'd0);
  endtask

  task automatic add_vec(input int px, input int py, input bit vis,
                         input logic [11:0] rgb, input string name);
    vec_t v;
    v.px = px; v.py = py; v.vis = vis; v.rgb = rgb; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_rgb"},  32'({vid.red_o, vid.green_o, vid.blue_o}), 32'd0);
    chk({name, "_sync"}, 32'({vid.hsync_o, vid.vsync_o}), 32'd0);
    chk({name, "_tick"}, 32'(vid.frame_tick_o), 32'd0);
  endtask

  initial begin
    // Scene A: left paddle y=100, right paddle y=450, ball at (100,200).
    add_vec(104, 204, 1'b1, C_BALL, "ball_center");
    add_vec(108, 204, 1'b1, C_BG,   "ball_right_out");
    add_vec(100, 200, 1'b1, C_BALL, "ball_top_left");
    add_vec(107, 207, 1'b1, C_BALL, "ball_bot_right");
    add_vec( 99, 204, 1'b1, C_BG,   "ball_left_out");
    add_vec(104, 208, 1'b1, C_BG,   "ball_below");
    add_vec( 16, 100, 1'b1, C_PAD,  "pl_top_left");
    add_vec( 23, 163, 1'b1, C_PAD,  "pl_bot_right");
    add_vec( 24, 120, 1'b1, C_BG,   "pl_right_out");
    add_vec( 16, 164, 1'b1, C_BG,   "pl_below");
    add_vec( 15, 120, 1'b1, C_BG,   "pl_left_out");
    add_vec( 16,  99, 1'b1, C_BG,   "pl_above");
    add_vec(616, 450, 1'b1, C_PAD,  "pr_top_left");
    add_vec(623, 479, 1'b1, C_PAD,  "pr_last_row");
    add_vec(624, 460, 1'b1, C_BG,   "pr_right_out");
    add_vec(615, 460, 1'b1, C_BG,   "pr_left_out");
    add_vec(620, 449, 1'b1, C_BG,   "pr_above");
    add_vec(620,   0, 1'b1, C_BG,   "pr_nowrap_row0");
    add_vec(620,  33, 1'b1, C_BG,   "pr_nowrap_row33");
    add_vec(104, 204, 1'b0, 12'h000, "invisible");
    add_vec(319,   0, 1'b1, C_NETX, "net_left");
    add_vec(320,  16, 1'b1, C_NETX, "net_right");
    add_vec(320,   8, 1'b1, C_BG,   "net_gap");
    add_vec(318,   0, 1'b1, C_BG,   "net_out_left");
    add_vec(321,   0, 1'b1, C_BG,   "net_out_right");

    vid.hsync_i = 1'b1;
    vid.vsync_i = 1'b1;
    vid.visible_range_i = 1'b0;
    vid.pixel_x_i = '0;
    vid.pixel_y_i = '0;
    set_pos(0, 0, 0, 0);

    rst = 1'b1;
    advance();
    advance();
    check_all_zero("reset_state");
    rst = 1'b0;

    set_pos(100, 450, 100, 200);
    frame_boundary();
    foreach (vecs[i]) drive(vecs[i].px, vecs[i].py, vecs[i].vis, 1'b1, 1'b1, vecs[i].rgb, vecs[i].name);

    // Sync edges and blanking: each must surface exactly 2 clocks later.
    drive(200, 10, 1'b1, 1'b0, 1'b1, C_BG,    "hs_fall");
    drive(200, 10, 1'b0, 1'b0, 1'b1, 12'h000, "blank_a");
    drive(200, 10, 1'b0, 1'b0, 1'b0, 12'h000, "vs_fall");
    drive(200, 10, 1'b1, 1'b1, 1'b0, C_BG,    "hs_rise");
    drive(200, 10, 1'b1, 1'b1, 1'b1, C_BG,    "vs_rise");

    // Ball on top of the left paddle.
    set_pos(100, 450, 20, 120);
    frame_boundary();
    pix(20, 120, C_BALL, "ovl_ball_wins");
    pix(16, 120, C_PAD,  "ovl_pad_left");
    pix(24, 120, C_BALL, "ovl_ball_right");
    pix(28, 120, C_BG,   "ovl_bg");
    pix(20, 128, C_PAD,  "ovl_pad_below");

    // Mid-frame position change must not show until the next frame tick.
    vid.paddle_l_y_i = Y_POS_W'(300);
    pix(20,  50, C_BG,  "mid_row50");
    pix(20, 100, C_PAD, "mid_old_top");
    pix(20, 300, C_BG,  "mid_new_top");
    pix(20, 163, C_PAD, "mid_old_bot");
    pix(20, 164, C_BG,  "mid_old_below");
    set_pos(300, 450, 500, 20);
    frame_boundary();
    pix(20, 300, C_PAD,  "new_top");
    pix(20, 363, C_PAD,  "new_bot");
    pix(20, 364, C_BG,   "new_below");
    pix(20, 100, C_BG,   "old_gone");
    pix(500, 20, C_BALL, "ball_moved");

    // Reset mid-line: in-flight pixels are dropped.
    pix(500, 20, C_BALL, "pre_rst_ball");
    pix(16, 300, C_PAD,  "pre_rst_pad");
    sb.delete();
    rst = 1'b1;
    advance();
    check_all_zero("rst_mid_1");
    advance();
    check_all_zero("rst_mid_2");
    rst = 1'b0;

    // Shadows hold reset positions (paddles at 208, ball centred) until a tick.
    pix( 20, 208, C_PAD,  "rst_pl_top");
    pix( 20, 207, C_BG,   "rst_pl_above");
    pix( 20, 271, C_PAD,  "rst_pl_bot");
    pix( 20, 272, C_BG,   "rst_pl_below");
    pix(620, 208, C_PAD,  "rst_pr_top");
    pix(316, 236, C_BALL, "rst_ball");
    pix(315, 236, C_BG,   "rst_ball_left");
    pix(500,  20, C_BG,   "rst_ball_input_ign");

    for (int i = 0; i < 3; i++) advance();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pong_renderer.md
PONG_RENDERER -- requirements
Module: pong_renderer

Interface
REQ-001 SHALL have parameter PADDLE_W, 8, paddle width in pixels.
REQ-002 SHALL have parameter PADDLE_H, 64, paddle height in pixels.
REQ-003 SHALL have parameter BALL_SZ, 8, ball edge length in pixels.
REQ-004 SHALL have parameter RGB_W, 4, bits per colour channel.
REQ-005 SHALL have clk_i  input  1  single system clock; reset is synchronous and active-high.
REQ-006 SHALL have rst_i  input  1  synchronous active-high reset.
REQ-007 SHALL have hsync_i, vsync_i  input  1 each  active-low syncs from the timing generator.
REQ-008 SHALL have pixel_x_i  input  X_POS_W  and  pixel_y_i  input  Y_POS_W  current pixel coordinate.
REQ-009 SHALL have visible_range_i  input  1  high while the pixel lies inside the active area.
REQ-010 SHALL have paddle_l_y_i, paddle_r_y_i, ball_y_i  input  Y_POS_W  top edge of each object.
REQ-011 SHALL have ball_x_i  input  X_POS_W  left edge of the ball.
REQ-012 SHALL have hsync_o, vsync_o  output  1  syncs delayed to match the RGB outputs.
REQ-013 SHALL have red_o, green_o, blue_o  output  RGB_W each  pixel colour.
REQ-014 SHALL have frame_tick_o  output  1  one-cycle pulse at the start of vertical blank.

Function
REQ-015 SHALL form a two-stage pipeline, advancing every clk_i cycle: stage 1 evaluates hit tests; stage 2 selects and registers the colour.
REQ-016 SHALL delay hsync_i, vsync_i and visible_range_i by exactly 2 cycles, so they stay aligned with the RGB outputs.
REQ-017 SHALL define in_vblank = (pixel_y_i >= SCREEN_V_RES) and register it each cycle.
REQ-018 SHALL assert frame_tick_o for exactly one cycle on the rising edge of in_vblank, even though the pixel inputs hold for several clk_i cycles.
REQ-019 SHALL capture all four position inputs into shadow registers in the same cycle that frame_tick_o asserts; hit tests SHALL use only the shadow values, so no tearing occurs mid-frame.
REQ-020 SHALL place the left paddle at x in [PADDLE_X_L, PADDLE_X_L+PADDLE_W) and the right paddle at x in [SCREEN_H_RES-PADDLE_X_L-PADDLE_W, SCREEN_H_RES-PADDLE_X_L).
REQ-021 SHALL place the left paddle at y in [paddle_l_y, paddle_l_y+PADDLE_H) and the right paddle likewise from paddle_r_y.
REQ-022 SHALL hit the ball at x in [ball_x, ball_x+BALL_SZ) and y in [ball_y, ball_y+BALL_SZ).
REQ-023 SHALL compute every upper bound one bit wider than its operand, so no wrap-around occurs; an object extending past the screen edge is clipped, not wrapped.
REQ-024 SHALL apply colour priority: ball > paddles > centre line (when compiled in) > background.
REQ-025 SHALL output COLOR_BALL, COLOR_PADDLE, COLOR_NET or COLOR_BG according to that priority.
REQ-026 SHALL drive RGB all-zero whenever the delayed visible_range is low.

Reset
REQ-027 SHALL, on rst_i, clear every RGB output, frame_tick_o, the pipeline registers and in_vblank_q to 0.
REQ-028 SHALL, on rst_i, drive hsync_o and vsync_o to 0, which equals the timing generator's reset state.
REQ-029 SHALL, on rst_i, reset the shadow paddle Y positions to (SCREEN_V_RES-PADDLE_H)/2 and the ball to the screen centre.
REQ-030 SHALL, when reset is asserted mid-frame, take effect on the next edge with no partial pipeline output.
REQ-031 SHALL, after reset release, keep the reset positions until the first frame_tick_o.

Configuration
REQ-032 SHALL, with PONG_CENTER_NET_EN defined, draw the centre net at x in [SCREEN_H_RES/2-1, SCREEN_H_RES/2+1).
REQ-033 SHALL draw the centre net only when pixel_y bit 3 is 0, giving 8-px dashes.
REQ-034 SHALL, without PONG_CENTER_NET_EN, generate no net logic and show background in that region.

Structure
REQ-035 SHALL place PADDLE_X_L (16), the COLOR_* constants and an rgb_t packed struct in display_pkg.
REQ-036 SHALL reuse X_POS_W, Y_POS_W, SCREEN_H_RES and SCREEN_V_RES from display_pkg.
REQ-037 SHALL use one sub-module, rect_hit, which is a registered point-in-rectangle test with parameterised size, instantiated once per object.

Verification (640x480 package values)
REQ-038 SHALL verify: ball_x=100, ball_y=200, then a frame boundary, then input (104,204) -> COLOR_BALL exactly 2 cycles later; input (108,204) -> COLOR_BG.
REQ-039 SHALL verify: paddle_l_y changes 100->300 while pixel_y=50 -> the rendered paddle stays at rows 100-163 until frame_tick_o, and frame_tick_o pulses once per frame.
REQ-040 SHALL verify: ball overlapping the left paddle at (20,120) -> COLOR_BALL wins.
REQ-041 SHALL verify: paddle_r_y=450 -> the paddle is drawn on rows 450-479 only, with no pixels on rows 0-33.
REQ-042 SHALL verify: visible_range_i low -> RGB=0, and sync edges appear on the outputs exactly 2 cycles after the inputs.
REQ-043 SHALL verify: rst_i asserted mid-line -> all outputs 0 on the next cycle; after release the paddles render centred at row 208.
